// File: rtl/ks_data_path_gen.sv
// K&S processor datapath: IR, PC, register file, ALU with registered flags, return-address stack.
// Latency: IR/register/flag/PC/stack updates visible one cycle after the enabling edge; ram_addr and data_out are combinational.
// Backpressure: none; the control unit owns every enable, and stack overflow/underflow are absorbed and flagged.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   ir_enable, pc_enable       IR load from data_in / PC update
//   branch, stack_push/pop     PC source selection and return-stack control
//   addr_sel, c_sel            ram_addr source / register write-data source
//   operation                  ALU function select
//   write_reg_enable           register file write of the decoded C register
//   flags_reg_enable           capture the ALU flags
//   data_in                    RAM read data
//   decoded_instruction        decoded IR
//   zero_op/neg_op/unsigned_overflow/signed_overflow   registered ALU flags
//   stack_overflow/stack_underflow/stack_level         return-stack status
//   ram_addr, data_out         RAM address and store data (R[a])

package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR, I_XOR, I_SHL, I_SHR,
    I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_CALL, I_RET, I_HALT
  } decoded_instruction_type;
endpackage

module ks_data_path_gen
  import k_and_s_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int REG_ADDR_W  = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ir_enable,
  input  logic                             pc_enable,
  input  logic                             branch,
  input  logic                             stack_push,
  input  logic                             stack_pop,
  input  logic                             addr_sel,
  input  logic                             c_sel,
  input  logic [2:0]                       operation,
  input  logic                             write_reg_enable,
  input  logic                             flags_reg_enable,
  input  logic [DATA_W-1:0]                data_in,
  output decoded_instruction_type          decoded_instruction,
  output logic                             zero_op,
  output logic                             neg_op,
  output logic                             unsigned_overflow,
  output logic                             signed_overflow,
  output logic                             stack_overflow,
  output logic                             stack_underflow,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [DATA_W-1:0]                data_out
);

  localparam int R     = REG_ADDR_W;
  localparam int NREG  = 2**R;
  localparam int M     = DATA_W - 1;
  localparam int LVL_W = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // ---------------------------------------------------------------- decode
  decoded_instruction_type dec;
  logic [R-1:0]      c_addr, a_addr, b_addr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        opcode;
  logic              unused_ir_bits;

  assign opcode = ir[M -: 8];
  // Some IR bits between the opcode and the operand fields are never decoded.
  assign unused_ir_bits = ^ir;

  always_comb begin
    dec    = I_NOP;
    c_addr = '0;
    a_addr = '0;
    b_addr = '0;
    addr   = '0;
    case (opcode)
      8'h81: begin dec = I_LOAD;  c_addr = ir[ADDR_W +: R]; addr = ir[ADDR_W-1:0]; end
      8'h82: begin dec = I_STORE; a_addr = ir[ADDR_W +: R]; addr = ir[ADDR_W-1:0]; end
      8'h91: begin dec = I_MOVE;  c_addr = ir[R +: R];      a_addr = ir[0 +: R];   end
      8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7: begin
        case (opcode[2:0])
          3'd1:    dec = I_ADD;
          3'd2:    dec = I_SUB;
          3'd3:    dec = I_AND;
          3'd4:    dec = I_OR;
          3'd5:    dec = I_XOR;
          3'd6:    dec = I_SHL;
          default: dec = I_SHR;
        endcase
        c_addr = ir[2*R +: R];
        a_addr = ir[R +: R];
        b_addr = ir[0 +: R];
      end
      8'h01: begin dec = I_BRANCH; addr = ir[ADDR_W-1:0]; end
      8'h02: begin dec = I_BZERO;  addr = ir[ADDR_W-1:0]; end
      8'h03: begin dec = I_BNEG;   addr = ir[ADDR_W-1:0]; end
      8'h05: begin dec = I_BOV;    addr = ir[ADDR_W-1:0]; end
      8'h06: begin dec = I_BNOV;   addr = ir[ADDR_W-1:0]; end
      8'h0A: begin dec = I_BNNEG;  addr = ir[ADDR_W-1:0]; end
      8'h0B: begin dec = I_BNZERO; addr = ir[ADDR_W-1:0]; end
      8'h07: begin dec = I_CALL;   addr = ir[ADDR_W-1:0]; end
      8'h08: dec = I_RET;
      8'hFF: dec = I_HALT;
      default: dec = I_NOP;
    endcase
  end

  assign decoded_instruction = dec;

  // ------------------------------------------------------------------- ALU
  logic [DATA_W-1:0] a_val, b_val, alu_res;
  logic [DATA_W:0]   sum;
  logic              alu_uov, alu_sov;

  assign a_val    = regs[a_addr];
  assign b_val    = regs[b_addr];
  assign data_out = a_val;

  always_comb begin
    sum     = '0;
    alu_res = a_val;
    alu_uov = 1'b0;
    alu_sov = 1'b0;
    case (operation)
      3'b000: begin
        sum     = {1'b0, a_val} + {1'b0, b_val};
        alu_res = sum[M:0];
        alu_uov = sum[DATA_W];
        alu_sov = (a_val[M] == b_val[M]) && (alu_res[M] != a_val[M]);
      end
      3'b001: begin
        // Carry-out of A + ~B + 1 is the inverted borrow.
        sum     = {1'b0, a_val} + {1'b0, ~b_val} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = sum[M:0];
        alu_uov = ~sum[DATA_W];
        alu_sov = (a_val[M] != b_val[M]) && (alu_res[M] != a_val[M]);
      end
      3'b010: alu_res = a_val & b_val;
      3'b011: alu_res = a_val | b_val;
      3'b100: alu_res = a_val ^ b_val;
      3'b101: begin
        alu_res = {a_val[M-1:0], 1'b0};
        alu_uov = a_val[M];
        alu_sov = a_val[M] ^ a_val[M-1];
      end
      3'b110: begin
        alu_res = {1'b0, a_val[M:1]};
        alu_uov = a_val[0];
      end
      default: alu_res = a_val;
    endcase
  end

  // ------------------------------------------------------------ return stack
  logic             stack_empty, stack_full, do_push;
  logic [IDX_W-1:0] top_idx, push_idx;

  assign stack_empty = (stack_level == '0);
  assign stack_full  = (stack_level == LVL_W'(STACK_DEPTH));
  // A push coinciding with a pop is dropped; the pop wins.
  assign do_push     = stack_push && !stack_pop && !stack_full;
  assign top_idx     = IDX_W'(stack_level - LVL_W'(1));
  assign push_idx    = IDX_W'(stack_level);

  always_ff @(posedge clk) begin
    if (!rst && do_push)
      stack_mem[push_idx] <= pc;
  end

  // --------------------------------------------------------- state update
  always_ff @(posedge clk) begin
    if (rst) begin
      ir                <= '0;
      pc                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      stack_level       <= '0;
      stack_overflow    <= 1'b0;
      stack_underflow   <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      if (ir_enable)
        ir <= data_in;

      if (write_reg_enable)
        regs[c_addr] <= c_sel ? data_in : alu_res;

      if (flags_reg_enable) begin
        zero_op           <= (alu_res == '0);
        neg_op            <= alu_res[M];
        unsigned_overflow <= alu_uov;
        signed_overflow   <= alu_sov;
      end

      if (pc_enable) begin
        if (stack_pop) begin
          if (!stack_empty)
            pc <= stack_mem[top_idx];
        end else if (branch) begin
          pc <= addr;
        end else begin
          pc <= pc + ADDR_W'(1);
        end
      end

      if (stack_pop) begin
        if (stack_empty)
          stack_underflow <= 1'b1;
        else
          stack_level <= stack_level - LVL_W'(1);
      end else if (stack_push) begin
        if (stack_full)
          stack_overflow <= 1'b1;
        else
          stack_level <= stack_level + LVL_W'(1);
      end
    end
  end

  assign ram_addr = addr_sel ? addr : pc;

endmodule

// File: tb/tb_ks_data_path_gen.sv
// Bench for ks_data_path_gen: directed vectors, expectations queued by stimulus, checked by a negedge monitor.
// Latency: checks sample on the negedge after the edge that applied the stimulus.
// Backpressure: not applicable; the monitor drains the whole queue on every check strobe.
module tb_ks_data_path_gen;
  import k_and_s_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int SD = 4;
  localparam int LW = $clog2(SD+1);

  logic clk, rst, ir_enable, pc_enable, branch, stack_push, stack_pop;
  logic addr_sel, c_sel, write_reg_enable, flags_reg_enable;
  logic [2:0]    operation;
  logic [DW-1:0] data_in, data_out;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;
  logic stack_overflow, stack_underflow;
  logic [LW-1:0] stack_level;
  logic [AW-1:0] ram_addr;

  ks_data_path_gen #(.DATA_W(DW), .ADDR_W(AW), .REG_ADDR_W(2), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .ir_enable(ir_enable), .pc_enable(pc_enable), .branch(branch),
    .stack_push(stack_push), .stack_pop(stack_pop), .addr_sel(addr_sel), .c_sel(c_sel),
    .operation(operation), .write_reg_enable(write_reg_enable), .flags_reg_enable(flags_reg_enable),
    .data_in(data_in), .decoded_instruction(decoded_instruction), .zero_op(zero_op),
    .neg_op(neg_op), .unsigned_overflow(unsigned_overflow), .signed_overflow(signed_overflow),
    .stack_overflow(stack_overflow), .stack_underflow(stack_underflow),
    .stack_level(stack_level), .ram_addr(ram_addr), .data_out(data_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_RADDR = 0, F_DOUT = 1, F_Z = 2, F_N = 3, F_U = 4, F_S = 5,
                 F_LVL = 6, F_OVF = 7, F_UNF = 8, F_DEC = 9;

  typedef struct {
    string       name;
    int          fld;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  bit   chk_vld = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [31:0] observe(int fld);
    case (fld)
      F_RADDR: return 32'(ram_addr);
      F_DOUT:  return 32'(data_out);
      F_Z:     return 32'(zero_op);
      F_N:     return 32'(neg_op);
      F_U:     return 32'(unsigned_overflow);
      F_S:     return 32'(signed_overflow);
      F_LVL:   return 32'(stack_level);
      F_OVF:   return 32'(stack_overflow);
      F_UNF:   return 32'(stack_underflow);
      default: return 32'(decoded_instruction);
    endcase
  endfunction

  // Monitor: drains every queued expectation whenever the stimulus raises the check strobe.
  always @(negedge clk) begin
    if (chk_vld) begin
      while (sb_q.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e   = sb_q.pop_front();
        got = observe(e.fld);
        n_total++;
        if (got === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, got, e.exp);
      end
    end
  end

  task automatic exp_push(string name, int fld, logic [31:0] v);
    exp_t e;
    e.name = name; e.fld = fld; e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic check_now();
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic idle();
    ir_enable = 0; pc_enable = 0; branch = 0; stack_push = 0; stack_pop = 0;
    addr_sel = 0; c_sel = 0; write_reg_enable = 0; flags_reg_enable = 0;
    operation = 3'b000; data_in = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk_ld(int c, int ad);  return {8'h81, 1'b0, 2'(c), 5'(ad)}; endfunction
  function automatic logic [15:0] mk_st(int a, int ad);  return {8'h82, 1'b0, 2'(a), 5'(ad)}; endfunction
  function automatic logic [15:0] mk_alu(logic [7:0] opc, int c, int a, int b);
    return {opc, 2'b00, 2'(c), 2'(a), 2'(b)};
  endfunction
  function automatic logic [15:0] mk_mv(int c, int a);   return {8'h91, 4'b0000, 2'(c), 2'(a)}; endfunction
  function automatic logic [15:0] mk_adr(logic [7:0] opc, int ad); return {opc, 3'b000, 5'(ad)}; endfunction

  task automatic ld_ir(logic [15:0] w);
    idle(); ir_enable = 1; data_in = w; cyc(); idle();
  endtask

  task automatic ld_reg(int c, logic [15:0] v);
    ld_ir(mk_ld(c, 0));
    c_sel = 1; write_reg_enable = 1; data_in = v; cyc(); idle();
  endtask

  task automatic rd_reg(string name, int r, logic [15:0] v);
    ld_ir(mk_st(r, 5'h0C));
    addr_sel = 1;
    exp_push({name, ".dout"}, F_DOUT, 32'(v));
    exp_push({name, ".addr"}, F_RADDR, 32'h0C);
    check_now();
    idle();
  endtask

  task automatic do_reset();
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      ir_enable = 1'($urandom); pc_enable = 1'($urandom); branch = 1'($urandom);
      stack_push = 1'($urandom); stack_pop = 1'($urandom); c_sel = 1'($urandom);
      write_reg_enable = 1'($urandom); flags_reg_enable = 1'($urandom);
      operation = 3'($urandom); data_in = 16'($urandom); addr_sel = 0;
      cyc();
    end
    rst = 0;
    idle();
  endtask

  task automatic chk_pc(string name, int pc, int lvl);
    exp_push({name, ".pc"}, F_RADDR, 32'(pc));
    exp_push({name, ".lvl"}, F_LVL, 32'(lvl));
    check_now();
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [7:0]  opc;
    logic [15:0] a, b, r;
    logic        z, n, u, s;
  } av_t;

  typedef struct {
    logic [7:0] opc;
    decoded_instruction_type d;
  } dv_t;

  av_t av[9];
  dv_t dv[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
    $fatal(1);
  end

  initial begin
    av[0] = '{"add_ovf",  3'b000, 8'hA1, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1};
    av[1] = '{"sub_brw",  3'b001, 8'hA2, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 1, 0};
    av[2] = '{"shl",      3'b101, 8'hA6, 16'hC001, 16'h0000, 16'h8002, 0, 1, 1, 0};
    av[3] = '{"shr",      3'b110, 8'hA7, 16'h0001, 16'h0000, 16'h0000, 1, 0, 1, 0};
    av[4] = '{"add_cry",  3'b000, 8'hA1, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0};
    av[5] = '{"sub_sov",  3'b001, 8'hA2, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1};
    av[6] = '{"and",      3'b010, 8'hA3, 16'hF0F0, 16'h0FF0, 16'h00F0, 0, 0, 0, 0};
    av[7] = '{"xor",      3'b100, 8'hA5, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0, 0};
    av[8] = '{"or",       3'b011, 8'hA4, 16'hF000, 16'h000F, 16'hF00F, 0, 1, 0, 0};

    dv[0] = '{8'h02, I_BZERO};
    dv[1] = '{8'h0B, I_BNZERO};
    dv[2] = '{8'hFF, I_HALT};
    dv[3] = '{8'h55, I_NOP};
    dv[4] = '{8'hA7, I_SHR};
    dv[5] = '{8'h06, I_BNOV};

    idle();
    rst = 0;

    // Reset with random enables.
    do_reset();
    exp_push("rst.pc",   F_RADDR, 0);
    exp_push("rst.z",    F_Z, 0);
    exp_push("rst.n",    F_N, 0);
    exp_push("rst.u",    F_U, 0);
    exp_push("rst.s",    F_S, 0);
    exp_push("rst.lvl",  F_LVL, 0);
    exp_push("rst.ovf",  F_OVF, 0);
    exp_push("rst.unf",  F_UNF, 0);
    exp_push("rst.dout", F_DOUT, 0);
    exp_push("rst.dec",  F_DEC, 32'(I_NOP));
    check_now();

    // Decode spot checks.
    ld_ir(mk_ld(1, 3));
    exp_push("dec.load", F_DEC, 32'(I_LOAD));
    check_now();
    foreach (dv[i]) begin
      ld_ir(mk_adr(dv[i].opc, 9));
      exp_push($sformatf("dec.%0h", dv[i].opc), F_DEC, 32'(dv[i].d));
      check_now();
    end

    // ALU vectors: R1 = A, R2 = B, R3 = op(R1, R2).
    foreach (av[i]) begin
      ld_reg(1, av[i].a);
      ld_reg(2, av[i].b);
      ld_ir(mk_alu(av[i].opc, 3, 1, 2));
      operation = av[i].op; write_reg_enable = 1; flags_reg_enable = 1;
      cyc(); idle();
      exp_push({av[i].name, ".z"}, F_Z, 32'(av[i].z));
      exp_push({av[i].name, ".n"}, F_N, 32'(av[i].n));
      exp_push({av[i].name, ".u"}, F_U, 32'(av[i].u));
      exp_push({av[i].name, ".s"}, F_S, 32'(av[i].s));
      check_now();
      rd_reg({av[i].name, ".r3"}, 3, av[i].r);
    end

    // MOVE R0 <- R3 through PASS.
    ld_ir(mk_mv(0, 3));
    exp_push("move.dec", F_DEC, 32'(I_MOVE));
    check_now();
    operation = 3'b111; write_reg_enable = 1; flags_reg_enable = 1;
    cyc(); idle();
    exp_push("move.n", F_N, 1);
    exp_push("move.z", F_Z, 0);
    exp_push("move.u", F_U, 0);
    check_now();
    rd_reg("move.r0", 0, 16'hF00F);

    // CALL / RET nesting.
    do_reset();
    for (int k = 0; k < 3; k++) begin pc_enable = 1; cyc(); idle(); end
    chk_pc("pc3", 3, 0);
    ld_ir(mk_adr(8'h07, 5'h10));
    exp_push("call.dec", F_DEC, 32'(I_CALL));
    check_now();
    stack_push = 1; branch = 1; pc_enable = 1; cyc(); idle();
    chk_pc("call1", 5'h10, 1);
    pc_enable = 1; cyc(); idle();
    ld_ir(mk_adr(8'h07, 5'h18));
    stack_push = 1; branch = 1; pc_enable = 1; cyc(); idle();
    chk_pc("call2", 5'h18, 2);
    ld_ir(16'h0800);
    exp_push("ret.dec", F_DEC, 32'(I_RET));
    check_now();
    stack_pop = 1; pc_enable = 1; cyc(); idle();
    chk_pc("ret1", 5'h11, 1);
    stack_pop = 1; pc_enable = 1; cyc(); idle();
    chk_pc("ret2", 3, 0);

    // Reset during a CALL cycle drops the push and PC change.
    ld_ir(mk_adr(8'h07, 5'h14));
    stack_push = 1; branch = 1; pc_enable = 1; rst = 1; cyc(); rst = 0; idle();
    chk_pc("rstcall", 0, 0);

    // Push without pc_enable, then push+pop acts as pop.
    stack_push = 1; cyc(); idle();
    chk_pc("push_nopc", 0, 1);
    for (int k = 0; k < 2; k++) begin pc_enable = 1; cyc(); idle(); end
    stack_push = 1; stack_pop = 1; pc_enable = 1; cyc(); idle();
    chk_pc("pushpop", 0, 0);
    exp_push("pushpop.ovf", F_OVF, 0);
    check_now();

    // Overflow: five pushes into a four-deep stack, PC counting along.
    for (int k = 0; k < 4; k++) begin stack_push = 1; pc_enable = 1; cyc(); idle(); end
    chk_pc("push4", 4, 4);
    exp_push("push4.ovf", F_OVF, 0);
    check_now();
    stack_push = 1; pc_enable = 1; cyc(); idle();
    chk_pc("push5", 5, 4);
    exp_push("push5.ovf", F_OVF, 1);
    check_now();

    // Underflow: four good pops return 3,2,1,0; fifth pop holds PC.
    for (int k = 0; k < 4; k++) begin
      stack_pop = 1; pc_enable = 1; cyc(); idle();
      chk_pc($sformatf("pop%0d", k + 1), 3 - k, 3 - k);
    end
    for (int k = 0; k < 2; k++) begin pc_enable = 1; cyc(); idle(); end
    stack_pop = 1; pc_enable = 1; cyc(); idle();
    chk_pc("pop5", 2, 0);
    exp_push("pop5.unf", F_UNF, 1);
    exp_push("pop5.ovf", F_OVF, 1);
    check_now();

    // Branch to 31, then increment wraps to 0; error flags remain sticky.
    ld_ir(mk_adr(8'h01, 31));
    exp_push("br.dec", F_DEC, 32'(I_BRANCH));
    check_now();
    branch = 1; pc_enable = 1; cyc(); idle();
    chk_pc("br31", 31, 0);
    pc_enable = 1; cyc(); idle();
    chk_pc("wrap", 0, 0);
    exp_push("wrap.ovf", F_OVF, 1);
    exp_push("wrap.unf", F_UNF, 1);
    check_now();

    do_reset();
    exp_push("clr.ovf", F_OVF, 0);
    exp_push("clr.unf", F_UNF, 0);
    check_now();

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
